// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART byte transmitter.
//   uart_tx_state_t : transmit FSM state encoding
//   UART_DATA_BITS  : payload bits per frame
//   UART_FRAME_BITS : start + data + stop bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while run is high and is held at
// 0 while run is low, so every frame starts on a fresh bit period.
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active low
//   run     : timer enable (frame in progress)
//   bit_end : high on the last cycle of each bit period
//   bit_pre : high on the cycle before the last one; lets the parent register
//             a pulse that lines up exactly with bit_end
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end,
  output logic bit_pre
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((CLKS_PER_BIT < 2) ? 0 : CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'((CLKS_PER_BIT < 2) ? 0 : CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d
    // unassigned; otherwise synthesis infers a latch.
    cnt_d = cnt_q;
    if (!run || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = run && (cnt_q == CNT_LAST);
  assign bit_pre = run && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// 8N1 UART transmitter with a one-byte holding register so the upstream word
// splitter can queue the next byte while the current one shifts out. A byte
// held before the last stop-bit cycle goes out back-to-back with no idle gap.
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   data_in  : byte to send, sampled when enable && ready
//   enable   : byte-valid strobe
//   ready    : holding register empty
//   tx       : serial line, idle high
//   busy     : frame in progress
//   done     : one-cycle pulse on the last cycle of each stop bit
//   overrun  : one-cycle pulse after a strobe that arrived while not ready
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       enable,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t   state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic load;     // move hold register into the shifter this cycle
  logic accept;   // take data_in into the hold register this cycle
  logic run;
  logic bit_end;
  logic bit_pre;

  assign run = (state_q != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .bit_end(bit_end),
    .bit_pre(bit_pre)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset along with the control flags so a
      // mid-frame reset leaves nothing stale that could leak into a later frame.
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: FSM, shifter and holding register
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // A queued byte chains straight into its start bit.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d = hold_q;
    end

    // accept and load are exclusive: load needs hold_full_q, accept needs !hold_full_q.
    accept      = enable && !hold_full_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  // Output logic: registered outputs are computed from the next state so they
  // change on the same edge as the FSM.
  always_comb begin
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d    = (state_d != IDLE);
    // Registered one cycle ahead so the pulse coincides with the last stop cycle.
    done_d    = (state_q == STOP) && bit_pre;
    overrun_d = enable && hold_full_q;
  end

  assign ready   = !hold_full_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
